// File: rtl/cnt_fifo_sched.sv
// Frame scheduler: selects each channel on upr, lets the mux settle, writes one
// FIFO word per channel, then drains the FIFO and signals frame completion.
module cnt_fifo_sched #(
    parameter int N_CH   = 8,
    parameter int CH_W   = 3,
    parameter int SETTLE = 3
) (
    input  logic            clk,
    input  logic            res,
    input  logic            ena,
    input  logic            start,
    input  logic            fifo_full,
    input  logic            fifo_empty,
    output logic [CH_W:0]   upr,
    output logic            w_fifo,
    output logic            r_fifo,
    output logic            busy,
    output logic            done,
    output logic [CH_W:0]   wr_cnt
);

    localparam int TW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int CW = CH_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEL,
        S_WRITE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          state, state_n;
    logic [CH_W-1:0] ch, ch_n;
    logic [TW-1:0]   timer, timer_n;
    logic [CH_W:0]   upr_n, cnt_n;
    logic            busy_n, done_n;

    // Strobes are the only outputs decoded combinationally from the registered state.
    assign w_fifo = (state == S_WRITE) && ena && !fifo_full;
    assign r_fifo = (state == S_DRAIN) && ena && !fifo_empty;

    always_comb begin
        state_n = state;
        ch_n    = ch;
        timer_n = timer;
        cnt_n   = wr_cnt;
        upr_n   = upr;
        busy_n  = busy;
        done_n  = 1'b0;
        if (ena) begin
            case (state)
                S_IDLE: begin
                    upr_n  = '0;
                    busy_n = 1'b0;
                    if (start) begin
                        state_n = S_SEL;
                        ch_n    = '0;
                        timer_n = '0;
                        cnt_n   = '0;
                        busy_n  = 1'b1;
                        upr_n   = {1'b1, {CH_W{1'b0}}};
                    end
                end
                S_SEL: begin
                    if (timer == TW'(SETTLE - 1)) begin
                        state_n = S_WRITE;
                        timer_n = '0;
                    end else begin
                        timer_n = timer + 1'b1;
                    end
                end
                S_WRITE: begin
                    if (!fifo_full) begin
                        if (wr_cnt < CW'(N_CH)) cnt_n = wr_cnt + 1'b1;
                        if (ch == CH_W'(N_CH - 1)) begin
                            state_n = S_DRAIN;
                            upr_n   = '0;
                        end else begin
                            state_n = S_SEL;
                            ch_n    = ch + 1'b1;
                            timer_n = '0;
                            upr_n   = {1'b1, ch + 1'b1};
                        end
                    end
                end
                S_DRAIN: begin
                    if (fifo_empty) begin
                        state_n = S_DONE;
                        done_n  = 1'b1;
                    end
                end
                S_DONE: begin
                    state_n = S_IDLE;
                    busy_n  = 1'b0;
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state  <= S_IDLE;
            ch     <= '0;
            timer  <= '0;
            upr    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            wr_cnt <= '0;
        end else begin
            state  <= state_n;
            ch     <= ch_n;
            timer  <= timer_n;
            upr    <= upr_n;
            busy   <= busy_n;
            done   <= done_n;
            wr_cnt <= cnt_n;
        end
    end

endmodule

// File: tb/tb_cnt_fifo_sched.sv
// Randomized bench for cnt_fifo_sched: input traces are generated up front, a
// frame-level walk of the scheduling rules produces the expected output trace.
module tb_cnt_fifo_sched;

    localparam int N_CH   = 8;
    localparam int CH_W   = 3;
    localparam int SETTLE = 3;
    localparam int LEN    = 400;
    localparam int W      = 12;

    logic            clk = 1'b0;
    logic            res, ena, start, fifo_full, fifo_empty;
    logic [CH_W:0]   upr, wr_cnt;
    logic            w_fifo, r_fifo, busy, done;

    cnt_fifo_sched #(.N_CH(N_CH), .CH_W(CH_W), .SETTLE(SETTLE)) dut (
        .clk(clk), .res(res), .ena(ena), .start(start),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .upr(upr), .w_fifo(w_fifo), .r_fifo(r_fifo),
        .busy(busy), .done(done), .wr_cnt(wr_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    logic in_ena [LEN];
    logic in_full [LEN];
    logic in_empty [LEN];
    logic in_start [LEN];

    // Expected per-cycle word: {upr, w_fifo, r_fifo, busy, done, wr_cnt}
    logic [W-1:0] exp_q[$];

    int           m_t;
    logic [CH_W:0] m_upr, m_cnt;
    logic          m_busy, m_done;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic bit live();
        return m_t < LEN;
    endfunction

    task automatic emit(input logic w, input logic r);
        if (m_t < LEN) begin
            exp_q.push_back({m_upr, w, r, m_busy, m_done, m_cnt});
            m_t++;
        end
    endtask

    // Walks whole frames over the input trace: idle until accepted start, per
    // channel count SETTLE enabled cycles then wait for a free write slot, drain
    // until empty, then one completion cycle.
    task automatic build_model();
        exp_q.delete();
        m_t = 0; m_upr = '0; m_cnt = '0; m_busy = 1'b0; m_done = 1'b0;
        while (live()) begin
            while (live() && !(in_start[m_t] && in_ena[m_t])) emit(1'b0, 1'b0);
            if (!live()) break;
            emit(1'b0, 1'b0);
            m_upr = 4'd8; m_busy = 1'b1; m_cnt = '0;
            for (int c = 0; c < N_CH; c++) begin
                int settle = 0;
                while (live() && settle < SETTLE) begin
                    if (in_ena[m_t]) settle++;
                    emit(1'b0, 1'b0);
                end
                while (live() && !(in_ena[m_t] && !in_full[m_t])) emit(1'b0, 1'b0);
                if (live()) begin
                    emit(1'b1, 1'b0);
                    if (m_cnt < N_CH) m_cnt = m_cnt + 1'b1;
                    m_upr = (c == N_CH - 1) ? 4'd0 : 4'(8 + c + 1);
                end
            end
            while (live() && !(in_ena[m_t] && in_empty[m_t]))
                emit(1'b0, in_ena[m_t] && !in_empty[m_t]);
            if (live()) begin
                emit(1'b0, 1'b0);
                m_done = 1'b1;
            end
            begin
                bit e;
                do begin
                    e = live() ? in_ena[m_t] : 1'b1;
                    emit(1'b0, 1'b0);
                    m_done = 1'b0;
                end while (live() && !e);
            end
            m_busy = 1'b0;
        end
    endtask

    task automatic gen_random(input int p_ena, input int p_full, input int p_empty, input int p_start);
        for (int k = 0; k < LEN; k++) begin
            in_ena[k]   = ($urandom_range(99) < p_ena);
            in_full[k]  = ($urandom_range(99) < p_full);
            in_empty[k] = ($urandom_range(99) < p_empty);
            in_start[k] = ($urandom_range(99) < p_start);
        end
    endtask

    task automatic do_reset();
        res = 1'b1; ena = 1'b0; start = 1'b0; fifo_full = 1'b0; fifo_empty = 1'b1;
        repeat (2) @(posedge clk);
        #1 res = 1'b0; ena = 1'b1;
        @(negedge clk);
        check_eq("rst_upr", upr, 0);
        check_eq("rst_w", w_fifo, 0);
        check_eq("rst_r", r_fifo, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_cnt", wr_cnt, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic run_scen(output int obs_w, output int obs_d);
        logic [W-1:0] e;
        obs_w = 0; obs_d = 0;
        for (int k = 0; k < LEN; k++) begin
            cyc = k;
            start = in_start[k]; ena = in_ena[k];
            fifo_full = in_full[k]; fifo_empty = in_empty[k];
            @(negedge clk);
            if (exp_q.size() == 0) begin
                check_eq("model_underrun", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check_eq("upr", upr, e[11:8]);
                check_eq("w_fifo", w_fifo, e[7]);
                check_eq("r_fifo", r_fifo, e[6]);
                check_eq("busy", busy, e[5]);
                check_eq("done", done, e[4]);
                check_eq("wr_cnt", wr_cnt, e[3:0]);
            end
            obs_w += int'(w_fifo);
            obs_d += int'(done);
            @(posedge clk);
            #1;
        end
    endtask

    int p_tab[4][4] = '{'{100, 0, 30, 10}, '{100, 40, 30, 20}, '{70, 20, 30, 20}, '{60, 50, 50, 50}};

    initial begin
        int nw, nd;
        for (int s = 0; s < 4; s++) begin
            do_reset();
            gen_random(p_tab[s][0], p_tab[s][1], p_tab[s][2], p_tab[s][3]);
            build_model();
            run_scen(nw, nd);
        end

        // Directed frame: full stall on ch 3, ena gaps in SEL of ch 5 and in
        // DRAIN, start re-requested while busy.
        do_reset();
        for (int k = 0; k < LEN; k++) begin
            in_start[k] = (k == 0) || (k == 10) || (k == 11);
            in_ena[k]   = !((k >= 27 && k <= 29) || k == 45 || k == 46);
            in_full[k]  = (k >= 16 && k <= 20);
            in_empty[k] = !(k >= 41 && k <= 48);
        end
        build_model();
        run_scen(nw, nd);
        check_eq("frame_writes", nw, N_CH);
        check_eq("frame_dones", nd, 1);

        // Reset during the ch 2 write slot aborts the frame.
        do_reset();
        for (int k = 0; k < 32; k++) begin
            cyc = k;
            start = (k == 0); ena = 1'b1;
            fifo_full = (k == 12); fifo_empty = 1'b0; res = (k == 12);
            @(negedge clk);
            if (k == 4) check_eq("ab_w0", w_fifo, 1);
            if (k == 12) check_eq("ab_upr_ch2", upr, 10);
            if (k == 13) check_eq("ab_cnt", wr_cnt, 0);
            if (k >= 13) begin
                check_eq("ab_upr", upr, 0);
                check_eq("ab_busy", busy, 0);
                check_eq("ab_w", w_fifo, 0);
                check_eq("ab_r", r_fifo, 0);
            end
            @(posedge clk);
            #1;
        end
        res = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
